// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes configuration words LSB-first onto a tile ccff chain, gating the chain clock.
// Define CCFF_LOADER_VERIFY_EN to add a CRC-8 readback pass that recirculates the chain after loading.

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 19,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);
    // state    | meaning
    // S_IDLE   | waiting for start
    // S_LOAD   | accepting words and shifting bits into the chain
    // S_VERIFY | recirculating the chain through ccff_tail, CRC over readback
    // S_DONE   | one-cycle completion pulse
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int REM_W  = $clog2(WORD_W + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] NWORDS_C    = WCNT_W'(NWORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                head_q, head_d;
    logic                shift_en_q, shift_en_d;
    logic                issue;
    logic                issue_bit;
    int                  left_bits;
    int                  take_bits;

`ifdef CCFF_LOADER_VERIFY_EN
    logic [7:0]          crc_ld_q, crc_ld_d;
    logic [7:0]          crc_tl_q, crc_tl_d;
    logic [7:0]          tail_crc_next;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic                error_q, error_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (bit_cnt_q == CHAIN_LEN_C) begin
`ifdef CCFF_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CCFF_LOADER_VERIFY_EN
            S_VERIFY: if (vcnt_q == '0) state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_ready    = (state_q == S_LOAD) && (rem_q == '0) &&
                        (bit_cnt_q < CHAIN_LEN_C) && (wcnt_q < NWORDS_C);
        busy          = (state_q == S_LOAD) || (state_q == S_VERIFY);
        done          = (state_q == S_DONE);
        ccff_shift_en = shift_en_q;
        ccff_head     = head_q;
        error         = 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
        // Loopback keeps the chain contents intact while it is read out.
        if (state_q == S_VERIFY) ccff_head = ccff_tail;
        error = error_q;
`endif
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rem_d      = rem_q;
        sreg_d     = sreg_q;
        wcnt_d     = wcnt_q;
        head_d     = head_q;
        shift_en_d = 1'b0;
        issue      = 1'b0;
        issue_bit  = 1'b0;
        left_bits  = CHAIN_LEN - int'(bit_cnt_q);
        take_bits  = (left_bits < WORD_W) ? left_bits : WORD_W;
`ifdef CCFF_LOADER_VERIFY_EN
        crc_ld_d      = crc_ld_q;
        crc_tl_d      = crc_tl_q;
        vcnt_d        = vcnt_q;
        error_d       = error_q;
        tail_crc_next = crc8_step(crc_tl_q, ccff_tail);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bit_cnt_d = '0;
                    rem_d     = '0;
                    sreg_d    = '0;
                    wcnt_d    = '0;
`ifdef CCFF_LOADER_VERIFY_EN
                    crc_ld_d  = '0;
                    crc_tl_d  = '0;
                    error_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                // rem counts bits still waiting behind the one currently on ccff_head.
                if (word_valid && word_ready) begin
                    issue     = 1'b1;
                    issue_bit = word_in[0];
                    sreg_d    = word_in >> 1;
                    rem_d     = REM_W'(take_bits - 1);
                    wcnt_d    = wcnt_q + 1'b1;
                end else if (rem_q != '0) begin
                    issue     = 1'b1;
                    issue_bit = sreg_q[0];
                    sreg_d    = sreg_q >> 1;
                    rem_d     = rem_q - 1'b1;
                end
                if (issue) begin
                    head_d     = issue_bit;
                    shift_en_d = 1'b1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
`ifdef CCFF_LOADER_VERIFY_EN
                    crc_ld_d   = crc8_step(crc_ld_q, issue_bit);
`endif
                end
`ifdef CCFF_LOADER_VERIFY_EN
                if (state_d == S_VERIFY) begin
                    shift_en_d = 1'b1;
                    vcnt_d     = CNT_W'(CHAIN_LEN - 1);
                end
`endif
            end
`ifdef CCFF_LOADER_VERIFY_EN
            S_VERIFY: begin
                crc_tl_d = tail_crc_next;
                if (vcnt_q != '0) begin
                    vcnt_d     = vcnt_q - 1'b1;
                    shift_en_d = 1'b1;
                end else begin
                    error_d = (tail_crc_next != crc_ld_q);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            sreg_q     <= '0;
            wcnt_q     <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_ld_q   <= '0;
            crc_tl_q   <= '0;
            vcnt_q     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rem_q      <= rem_d;
            sreg_q     <= sreg_d;
            wcnt_q     <= wcnt_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_ld_q   <= crc_ld_d;
            crc_tl_q   <= crc_tl_d;
            vcnt_q     <= vcnt_d;
            error_q    <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural ccff chain on head/tail plus a bit scoreboard of expected head values.
// Verify-mode scenarios are built when CCFF_LOADER_VERIFY_EN is defined.

module tb_ccff_chain_loader;
    localparam int CL = 19;
    localparam int WW = 8;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic [WW-1:0] word_in;
    logic          word_valid;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          ccff_shift_en;
    logic          busy;
    logic          done;
    logic          error;

    logic [CL-1:0] chain;
    logic          flip_tail;
    logic [WW-1:0] wv [3];
    bit            exp_q [$];
    bit            obs_q [$];
    int            total = 0;
    int            bad = 0;

    int g_shifts, g_vshifts, g_done_cnt, g_done_cyc, g_last_load, g_last_ver;
    int g_first_shift, g_acc0, g_gap_shift, g_timeout;
    logic g_err_at_done;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en), .busy(busy),
        .done(done), .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    // Fabric chain: bit CL-1 sits at the head, bit 0 drives the tail.
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
    assign ccff_tail = chain[0] ^ flip_tail;

    function automatic logic [CL-1:0] exp_chain();
        logic [CL-1:0] r;
        for (int i = 0; i < CL; i++) r[i] = wv[i / WW][i % WW];
        return r;
    endfunction

    task automatic push_expected();
        exp_q.delete();
        for (int i = 0; i < CL; i++) exp_q.push_back(wv[i / WW][i % WW]);
    endtask

    task automatic pulse_start();
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    // Feeds wv[0..2]; gap = cycles word_valid is withheld while word_ready is high between words.
    task automatic drive_load(input int gap, input bit start_mid, input int flip_at);
        int cyc = 0, widx = 0, gcnt = 0;
        g_shifts = 0; g_vshifts = 0; g_done_cnt = 0; g_done_cyc = 0; g_last_load = 0;
        g_last_ver = 0; g_first_shift = -1; g_acc0 = 0; g_gap_shift = 0; g_timeout = 0;
        g_err_at_done = 1'b0;
        obs_q.delete();
        word_valid = 1'b0;
        flip_tail = 1'b0;
        while (cyc < 300) begin
            @(negedge prog_clk);
            cyc++;
            flip_tail = 1'b0;
            if (ccff_shift_en) begin
                if (g_shifts < CL) begin
                    obs_q.push_back(ccff_head);
                    g_shifts++;
                    g_last_load = cyc;
                    if (g_first_shift < 0) g_first_shift = cyc;
                end else begin
                    g_vshifts++;
                    g_last_ver = cyc;
                    if (g_vshifts == flip_at) flip_tail = 1'b1;
                end
            end else if (g_first_shift >= 0 && g_shifts < CL) begin
                g_gap_shift++;
            end
            if (done) begin
                g_done_cnt++;
                g_done_cyc = cyc;
                g_err_at_done = error;
            end
            if (g_done_cnt > 0 && !done) break;
            start = start_mid && (g_shifts == 5);
            word_valid = (widx < 3) && (widx == 0 || gcnt == 0);
            word_in = (widx < 3) ? wv[widx] : '0;
            if (word_valid && word_ready) begin
                if (widx == 0) g_acc0 = cyc;
                widx++;
                gcnt = gap;
            end else if (!word_valid && word_ready && gcnt > 0) begin
                gcnt--;
            end
        end
        if (cyc >= 300) g_timeout = 1;
        word_valid = 1'b0;
        start = 1'b0;
        flip_tail = 1'b0;
    endtask

    task automatic test_reset();
        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0; flip_tail = 1'b0;
        repeat (2) @(negedge prog_clk);
        total++;
        if ({word_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
            bad++;
            $display("FAIL rst_outputs got=%b want=000000",
                     {word_ready, ccff_head, ccff_shift_en, busy, done, error});
        end
        pReset = 1'b0;
        repeat (2) @(negedge prog_clk);
        total++;
        if ({word_ready, ccff_shift_en, busy, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL idle_outputs got=%b want=00000",
                     {word_ready, ccff_shift_en, busy, done, error});
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wv[0] = 8'hA5; wv[1] = 8'h3C; wv[2] = 8'h05;
        push_expected();
        pulse_start();
        total++;
        if ({busy, word_ready} !== 2'b11) begin
            bad++;
            $display("FAIL bb_start_resp got=%b want=11", {busy, word_ready});
        end
        drive_load(0, 1'b0, 0);
        total++;
        if (g_timeout != 0) begin bad++; $display("FAIL bb_timeout got=%0d want=0", g_timeout); end
        while (exp_q.size() > 0) begin
            bit e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
            total++;
            if (o !== e) begin bad++; $display("FAIL bb_head bit%0d got=%0d want=%0d", n, o, e); end
            n++;
        end
        total++;
        if (g_last_load - g_first_shift !== CL - 1 || g_gap_shift !== 0) begin
            bad++;
            $display("FAIL bb_contiguous span=%0d stalls=%0d want span=%0d stalls=0",
                     g_last_load - g_first_shift, g_gap_shift, CL - 1);
        end
        total++;
        if (g_first_shift !== g_acc0 + 1) begin
            bad++;
            $display("FAIL bb_first_latency got=%0d want=%0d", g_first_shift, g_acc0 + 1);
        end
        total++;
        if (chain !== exp_chain()) begin
            bad++;
            $display("FAIL bb_chain got=%h want=%h", chain, exp_chain());
        end
        total++;
        if (g_done_cnt !== 1) begin bad++; $display("FAIL bb_done_count got=%0d want=1", g_done_cnt); end
`ifdef CCFF_LOADER_VERIFY_EN
        total++;
        if (g_vshifts !== CL) begin bad++; $display("FAIL bb_verify_len got=%0d want=%0d", g_vshifts, CL); end
        total++;
        if (g_done_cyc !== g_last_ver + 1) begin
            bad++;
            $display("FAIL bb_done_timing got=%0d want=%0d", g_done_cyc, g_last_ver + 1);
        end
`else
        total++;
        if (g_vshifts !== 0) begin bad++; $display("FAIL bb_extra_shift got=%0d want=0", g_vshifts); end
        total++;
        if (g_done_cyc !== g_last_load + 1) begin
            bad++;
            $display("FAIL bb_done_timing got=%0d want=%0d", g_done_cyc, g_last_load + 1);
        end
`endif
        total++;
        if (g_err_at_done !== 1'b0) begin bad++; $display("FAIL bb_error got=%0d want=0", g_err_at_done); end
    endtask

    task automatic test_gaps();
        int n = 0;
        wv[0] = 8'hA5; wv[1] = 8'h3C; wv[2] = 8'h05;
        push_expected();
        pulse_start();
        drive_load(3, 1'b0, 0);
        while (exp_q.size() > 0) begin
            bit e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
            total++;
            if (o !== e) begin bad++; $display("FAIL gap_head bit%0d got=%0d want=%0d", n, o, e); end
            n++;
        end
        total++;
        if (g_gap_shift !== 6 || g_shifts !== CL) begin
            bad++;
            $display("FAIL gap_stalls stalls=%0d shifts=%0d want stalls=6 shifts=%0d",
                     g_gap_shift, g_shifts, CL);
        end
        total++;
        if (chain !== exp_chain()) begin
            bad++;
            $display("FAIL gap_chain got=%h want=%h", chain, exp_chain());
        end
        total++;
        if (g_timeout != 0 || g_done_cnt !== 1) begin
            bad++;
            $display("FAIL gap_done timeout=%0d done_count=%0d want 0 and 1", g_timeout, g_done_cnt);
        end
    endtask

    task automatic test_reset_midload();
        int n = 0, k = 0;
        wv[0] = 8'hA5; wv[1] = 8'h3C; wv[2] = 8'h05;
        pulse_start();
        word_valid = 1'b1;
        word_in = wv[0];
        for (int c = 0; c < 40 && n < 7; c++) begin
            @(negedge prog_clk);
            if (ccff_shift_en) n++;
        end
        total++;
        if (n !== 7) begin bad++; $display("FAIL rm_reach7 got=%0d want=7", n); end
        pReset = 1'b1;
        #1;
        total++;
        if ({word_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
            bad++;
            $display("FAIL rm_outputs got=%b want=000000",
                     {word_ready, ccff_head, ccff_shift_en, busy, done, error});
        end
        word_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
        wv[0] = 8'h5A; wv[1] = 8'hC3; wv[2] = 8'h06;
        push_expected();
        pulse_start();
        drive_load(0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            bit e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
            total++;
            if (o !== e) begin bad++; $display("FAIL rm_head bit%0d got=%0d want=%0d", k, o, e); end
            k++;
        end
        total++;
        if (chain !== exp_chain()) begin
            bad++;
            $display("FAIL rm_chain got=%h want=%h", chain, exp_chain());
        end
    endtask

    task automatic test_start_ignored();
        wv[0] = 8'h96; wv[1] = 8'h0F; wv[2] = 8'hFB;
        push_expected();
        pulse_start();
        drive_load(0, 1'b1, 0);
        total++;
        if (g_shifts !== CL || g_done_cnt !== 1 || g_timeout != 0) begin
            bad++;
            $display("FAIL si_count shifts=%0d done_count=%0d timeout=%0d want %0d,1,0",
                     g_shifts, g_done_cnt, g_timeout, CL);
        end
        total++;
        if (chain !== exp_chain()) begin
            bad++;
            $display("FAIL si_chain got=%h want=%h", chain, exp_chain());
        end
    endtask

`ifdef CCFF_LOADER_VERIFY_EN
    task automatic test_verify_error();
        wv[0] = 8'hA5; wv[1] = 8'h3C; wv[2] = 8'h05;
        pulse_start();
        drive_load(0, 1'b0, 5);
        total++;
        if (g_err_at_done !== 1'b1 || g_vshifts !== CL) begin
            bad++;
            $display("FAIL ve_error got=%0d vshifts=%0d want 1 and %0d", g_err_at_done, g_vshifts, CL);
        end
        pulse_start();
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL ve_clear got=%0d want=0", error); end
        drive_load(0, 1'b0, 0);
        total++;
        if (g_err_at_done !== 1'b0 || chain !== exp_chain()) begin
            bad++;
            $display("FAIL ve_reload error=%0d chain=%h want 0 and %h", g_err_at_done, chain, exp_chain());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_reset_midload();
        test_start_ignored();
`ifdef CCFF_LOADER_VERIFY_EN
        test_verify_error();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
